lattice_result_collector: RTL

- Consumer at the far end of the processor result lattice. Issues work rounds to the processor array and tracks which issue cycle each chain output belongs to.
- Captures the first successful result and reconstructs the winning nonce from the base, issue slot and processor index.
- Reports success or exhaustion to the host over a valid/ready handshake.

---
 rtl/lattice_result_collector.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lattice_result_collector.sv
// Result collector for the processor lattice: issues work rounds, tracks in-flight issue
// cycles, reconstructs the first winning nonce and reports it over a valid/ready handshake.
module lattice_result_collector #(
  parameter int unsigned COUNTBITS = 4,
  parameter int unsigned LATENCY   = 8,
  parameter int unsigned NONCEBITS = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NONCEBITS-1:0]           base_nonce,
  input  logic [NONCEBITS-COUNTBITS-1:0] num_issues,
  output logic                           issue_o,
  input  logic                           res_success,
  input  logic [COUNTBITS-1:0]           res_index,
  output logic                           busy,
  output logic                           out_valid,
  output logic                           out_found,
  output logic [NONCEBITS-1:0]           out_nonce,
  input  logic                           out_ready
);

  localparam int unsigned IW = NONCEBITS - COUNTBITS;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StReport} state_e;

  state_e                 state_q, state_d;
  logic [NONCEBITS-1:0]   base_q, base_d;
  logic [IW-1:0]          nissue_q, nissue_d;
  logic [IW-1:0]          icnt_q, icnt_d;
  logic [IW-1:0]          rcnt_q, rcnt_d;
  logic [LATENCY-1:0]     infl_q, infl_d;
  logic [LATENCY:0]       infl_shift;
  logic                   issue_q, issue_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   found_q, found_d;
  logic [NONCEBITS-1:0]   nonce_q, nonce_d;
  logic                   res_valid;
  logic                   hit;
  logic [NONCEBITS-1:0]   win_nonce;

  // The tap of the in-flight line marks the cycle whose chain output belongs to issue rcnt_q.
  assign res_valid  = infl_q[LATENCY-1];
  assign hit        = res_valid && res_success;
  assign infl_shift = {infl_q, issue_q};
  assign win_nonce  = base_q + {rcnt_q, {COUNTBITS{1'b0}}} + NONCEBITS'(res_index);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    nissue_d = nissue_q;
    icnt_d   = icnt_q;
    rcnt_d   = rcnt_q;
    infl_d   = infl_shift[LATENCY-1:0];
    issue_d  = 1'b0;
    valid_d  = valid_q;
    found_d  = found_q;
    nonce_d  = nonce_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d   = base_nonce;
          nissue_d = num_issues;
          icnt_d   = '0;
          rcnt_d   = '0;
          found_d  = 1'b0;
          nonce_d  = '0;
          if (num_issues == '0) begin
            state_d = StReport;
            valid_d = 1'b1;
          end else begin
            state_d = StRun;
            issue_d = 1'b1;
          end
        end
      end
      StRun, StDrain: begin
        if (state_q == StRun) begin
          icnt_d = icnt_q + IW'(1);
        end
        if (res_valid) begin
          rcnt_d = rcnt_q + IW'(1);
        end
        // A success takes priority over both the last-issue and the drain-empty transitions.
        if (hit) begin
          state_d = StReport;
          valid_d = 1'b1;
          found_d = 1'b1;
          nonce_d = win_nonce;
          infl_d  = '0;
        end else if (state_q == StRun) begin
          if (icnt_q + IW'(1) == nissue_q) begin
            state_d = StDrain;
          end else begin
            issue_d = 1'b1;
          end
        end else if (infl_d == '0) begin
          state_d = StReport;
          valid_d = 1'b1;
          found_d = 1'b0;
          nonce_d = '0;
        end
      end
      StReport: begin
        if (out_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      base_q   <= '0;
      nissue_q <= '0;
      icnt_q   <= '0;
      rcnt_q   <= '0;
      infl_q   <= '0;
      issue_q  <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      found_q  <= 1'b0;
      nonce_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      nissue_q <= nissue_d;
      icnt_q   <= icnt_d;
      rcnt_q   <= rcnt_d;
      infl_q   <= infl_d;
      issue_q  <= issue_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      found_q  <= found_d;
      nonce_q  <= nonce_d;
    end
  end

  assign issue_o   = issue_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_found = found_q;
  assign out_nonce = nonce_q;

endmodule
